// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared defaults for the round-robin handshake arbiter and its picker.
package handshake_rr_arbiter_pkg;

    localparam int N_SRC_DEF = 4;
    localparam int DW_DEF    = 8;
    localparam int SW_DEF    = 2;

endpackage

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so the slot after
// last_grant sits at bit 0, take the lowest set bit, rotate the index back.
module handshake_rr_arbiter_rr_pick
    import handshake_rr_arbiter_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SW-1:0]    last_grant,
    output logic             gnt_vld,
    output logic [SW-1:0]    gnt_idx
);

    localparam logic [SW-1:0] LAST_IDX = SW'(N_SRC - 1);
    localparam logic [SW:0]   N_WIDE   = (SW + 1)'(N_SRC);

    logic [SW-1:0]        start_s;
    logic [2*N_SRC-1:0]   dbl_s;
    logic [2*N_SRC-1:0]   shifted_s;
    logic [N_SRC-1:0]     rot_s;
    logic [SW-1:0]        off_s;
    logic [SW:0]          sum_s;

    // Rotate the request vector so the highest-priority slot is bit 0.
    always_comb begin
        start_s   = (last_grant >= LAST_IDX) ? {SW{1'b0}} : last_grant + {{(SW-1){1'b0}}, 1'b1};
        dbl_s     = {req, req};
        shifted_s = dbl_s >> start_s;
        rot_s     = shifted_s[N_SRC-1:0];
    end

    // Lowest set bit of the rotated vector; scanning downward lets bit 0 win last.
    always_comb begin
        off_s = {SW{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? SW'(i) : off_s;
        end
    end

    // Undo the rotation with a modulo-N add (sum never exceeds 2N-2).
    always_comb begin
        sum_s   = {1'b0, start_s} + {1'b0, off_s};
        gnt_idx = (sum_s >= N_WIDE) ? SW'(sum_s - N_WIDE) : SW'(sum_s);
        gnt_vld = |rot_s;
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready byte channel among N_SRC
// senders through a single registered output stage (1 beat/cycle, 1-cycle latency).
module handshake_rr_arbiter
    import handshake_rr_arbiter_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int DW    = DW_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_SRC-1:0]    s_valid_i,
    input  logic [N_SRC*DW-1:0] s_data_i,
    output logic [N_SRC-1:0]    s_ready_o,
    output logic                m_valid_o,
    output logic [DW-1:0]       m_data_o,
    output logic [SW-1:0]       m_src_o,
    input  logic                m_ready_i
);

    localparam logic [SW-1:0] LAST_IDX = SW'(N_SRC - 1);

    logic                load_en_s;
    logic                up_xfer_s;
    logic                dn_xfer_s;
    logic                gnt_vld_s;
    logic [SW-1:0]       gnt_idx_s;
    logic [DW-1:0]       win_data_s;
    logic [N_SRC-1:0]    ready_s;

    logic                m_valid_r;
    logic [DW-1:0]       m_data_r;
    logic [SW-1:0]       m_src_r;
    logic [SW-1:0]       last_grant_r;

    handshake_rr_arbiter_rr_pick #(
        .N_SRC (N_SRC),
        .SW    (SW)
    ) u_pick (
        .req        (s_valid_i),
        .last_grant (last_grant_r),
        .gnt_vld    (gnt_vld_s),
        .gnt_idx    (gnt_idx_s)
    );

    // Ready is gated by rst_n so no sender sees a handshake while reset is held.
    always_comb begin
        load_en_s  = !m_valid_r || m_ready_i;
        up_xfer_s  = rst_n && load_en_s && gnt_vld_s;
        dn_xfer_s  = m_valid_r && m_ready_i;
        win_data_s = {DW{1'b0}};
        ready_s    = {N_SRC{1'b0}};
        for (int k = 0; k < N_SRC; k++) begin
            ready_s[k] = up_xfer_s && (gnt_idx_s == SW'(k));
            win_data_s = (gnt_idx_s == SW'(k)) ? s_data_i[k*DW +: DW] : win_data_s;
        end
    end

    // Output stage and priority pointer; a new beat overwrites a draining one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r    <= 1'b0;
            m_data_r     <= {DW{1'b0}};
            m_src_r      <= {SW{1'b0}};
            last_grant_r <= LAST_IDX;
        end else if (up_xfer_s) begin
            m_valid_r    <= 1'b1;
            m_data_r     <= win_data_s;
            m_src_r      <= gnt_idx_s;
            last_grant_r <= gnt_idx_s;
        end else if (dn_xfer_s) begin
            m_valid_r    <= 1'b0;
            m_data_r     <= {DW{1'b0}};
            m_src_r      <= {SW{1'b0}};
            last_grant_r <= last_grant_r;
        end else begin
            m_valid_r    <= m_valid_r;
            m_data_r     <= m_data_r;
            m_src_r      <= m_src_r;
            last_grant_r <= last_grant_r;
        end
    end

    assign s_ready_o = ready_s;
    assign m_valid_o = m_valid_r;
    assign m_data_o  = m_data_r;
    assign m_src_o   = m_src_r;

endmodule
